regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (write enable, destination address, write data) between two writeback sources.
  - Source 1: the single-cycle ALU writeback path.
  - Source 2: the long-latency load/store and mul/div return path.
- The ALU path has priority. Long-latency results are buffered in a small FIFO.
- A starvation counter forces the buffered path through after a bounded number of consecutive losses.
- Outputs are registered and drive the register file write port directly.

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/wb_fifo.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback types for the register file write-port arbiter.
// Both writeback sources describe a write as a destination register plus data.
package regfile_wb_arbiter_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_req_t          push_data_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Reset clears every slot so a discarded entry can never reappear at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= push_data_i;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU writeback path (priority)
// and a buffered long-latency return path protected by a starvation counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int DATA_W     = WB_DATA_W,
  parameter  int ADDR_W     = WB_ADDR_W,
  parameter  int FIFO_DEPTH = 2,
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  wb_req_t           lsuReq;
  wb_req_t           headReq;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic              aluWins;
  logic              fifoWins;
  logic [STV_W-1:0]  starveCnt_q, starveCnt_d;
  logic              rfWe_q, rfWe_d;
  logic [ADDR_W-1:0] rfAddr_q, rfAddr_d;
  logic [DATA_W-1:0] rfData_q, rfData_d;

  assign lsuReq    = '{rd: lsu_rd, data: lsu_data};
  assign lsu_ready = !fifoFull;
  assign fifoPush  = lsu_valid && lsu_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifoPush),
    .push_data_i(lsuReq),
    .pop_i      (fifoPop),
    .head_o     (headReq),
    .count_o    (fifo_count),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // The FIFO only sees registered occupancy, so a same-cycle push cannot win.
  always_comb begin
    fifoWins    = !fifoEmpty && (!alu_valid || (starveCnt_q == STV_W'(STARVE_MAX)));
    aluWins     = alu_valid && !fifoWins;
    fifoPop     = fifoWins;
    alu_stall   = alu_valid && !aluWins;
    starveCnt_d = starveCnt_q;
    rfWe_d      = 1'b0;
    rfAddr_d    = rfAddr_q;
    rfData_d    = rfData_q;

    if (fifoEmpty || fifoWins) begin
      starveCnt_d = '0;
    end else if (aluWins && (starveCnt_q != STV_W'(STARVE_MAX))) begin
      starveCnt_d = starveCnt_q + STV_W'(1);
    end

    // Writes to r0 are consumed like any other win but never enabled.
    if (aluWins) begin
      rfWe_d   = (alu_rd != '0);
      rfAddr_d = alu_rd;
      rfData_d = alu_data;
    end else if (fifoWins) begin
      rfWe_d   = (headReq.rd != '0);
      rfAddr_d = headReq.rd;
      rfData_d = headReq.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
      rfWe_q      <= 1'b0;
      rfAddr_q    <= '0;
      rfData_q    <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      rfWe_q      <= rfWe_d;
      rfAddr_q    <= rfAddr_d;
      rfData_q    <= rfData_d;
    end
  end

  assign rf_we   = rfWe_q;
  assign rf_addr = rfAddr_q;
  assign rf_data = rfData_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a queue-based
// model of the writeback arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_stall;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd = '0;
  logic [DW-1:0] lsu_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [CW-1:0] fifo_count;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: pending long-latency results as a queue, plus the count of
  // consecutive ALU wins and the write the register file should see next.
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        modelQ[$];
  int            starve;
  logic          expWe;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;
  logic          lastStall;
  logic          lastReady;
  int            total = 0;
  int            bad = 0;

  logic          aluV;
  logic [AW-1:0] aluRd;
  logic [DW-1:0] aluData;
  logic          lsuV;
  logic [AW-1:0] lsuRd;
  logic [DW-1:0] lsuData;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    starve    = 0;
    expWe     = 1'b0;
    expAddr   = '0;
    expData   = '0;
    lastStall = 1'b0;
    lastReady = 1'b1;
  endtask

  // One clock cycle: drive the current request set, check the combinational
  // handshake, advance the model, then check the registered write port.
  task automatic applyStimulus();
    bit     haveF, aluWin, fifoWin, expStall, expReady;
    entry_t head;
    @(negedge clk);
    alu_valid = aluV;
    alu_rd    = aluRd;
    alu_data  = aluData;
    lsu_valid = lsuV;
    lsu_rd    = lsuRd;
    lsu_data  = lsuData;
    #1;
    haveF    = (modelQ.size() > 0);
    expReady = (modelQ.size() < DEPTH);
    fifoWin  = haveF && (!aluV || starve == SMAX);
    aluWin   = aluV && !fifoWin;
    expStall = aluV && !aluWin;
    checkOutput("alu_stall", 64'(alu_stall), 64'(expStall));
    checkOutput("lsu_ready", 64'(lsu_ready), 64'(expReady));
    checkOutput("fifo_count", 64'(fifo_count), 64'(modelQ.size()));
    lastStall = expStall;
    lastReady = expReady;

    expWe = 1'b0;
    if (aluWin) begin
      expWe   = (aluRd != 0);
      expAddr = aluRd;
      expData = aluData;
    end else if (fifoWin) begin
      head    = modelQ.pop_front();
      expWe   = (head.rd != 0);
      expAddr = head.rd;
      expData = head.data;
    end
    if (!haveF || fifoWin) starve = 0;
    else if (aluWin && starve < SMAX) starve = starve + 1;
    if (lsuV && expReady) modelQ.push_back('{rd: lsuRd, data: lsuData});

    @(posedge clk);
    #1;
    checkOutput("rf_we", 64'(rf_we), 64'(expWe));
    checkOutput("rf_addr", 64'(rf_addr), 64'(expAddr));
    checkOutput("rf_data", 64'(rf_data), 64'(expData));
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    aluV      = 1'b0;
    lsuV      = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_rf_we", 64'(rf_we), 64'(0));
    checkOutput("reset_rf_addr", 64'(rf_addr), 64'(0));
    checkOutput("reset_rf_data", 64'(rf_data), 64'(0));
    checkOutput("reset_fifo_count", 64'(fifo_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_lsu_ready", 64'(lsu_ready), 64'(1));
    checkOutput("release_alu_stall", 64'(alu_stall), 64'(0));
  endtask

  task automatic idle(input int n);
    aluV = 1'b0;
    lsuV = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic setAlu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    aluV = v; aluRd = rd; aluData = d;
  endtask

  task automatic setLsu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    lsuV = v; lsuRd = rd; lsuData = d;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int aluIdx;
    int lsuLeft;
    setAlu(0, 0, 0);
    setLsu(0, 0, 0);
    modelReset();
    #12;
    checkOutput("por_rf_we", 64'(rf_we), 64'(0));
    checkOutput("por_fifo_count", 64'(fifo_count), 64'(0));
    applyReset();

    // ALU only.
    setAlu(1, 7, 32'hDEADBEEF);
    setLsu(0, 0, 0);
    applyStimulus();
    idle(2);

    // LSU only: write appears two edges after the push.
    setLsu(1, 3, 32'h11);
    applyStimulus();
    idle(3);

    // Starvation: one buffered entry against a continuous ALU stream.
    setLsu(1, 9, 32'h99);
    setAlu(0, 0, 0);
    applyStimulus();
    setLsu(0, 0, 0);
    aluIdx = 1;
    for (int c = 0; c < 8; c++) begin
      if (!lastStall || !aluV) begin
        setAlu(1, AW'(10 + aluIdx), 32'hA000 + aluIdx);
        aluIdx++;
      end
      applyStimulus();
    end
    idle(2);

    // Full FIFO under a saturating ALU: three pushes, third held until space.
    lsuLeft = 3;
    setLsu(1, 20, 32'h2000);
    for (int c = 0; c < 16; c++) begin
      if (!lastStall || !aluV) begin
        setAlu(1, AW'(1 + (aluIdx % 15)), 32'hB000 + aluIdx);
        aluIdx++;
      end
      if (lsuV && lastReady && c > 0) begin
        lsuLeft--;
        if (lsuLeft > 0) setLsu(1, AW'(23 - lsuLeft), 32'h2000 + 32'(3 - lsuLeft));
        else setLsu(0, 0, 0);
      end
      applyStimulus();
    end
    idle(4);

    // r0 writes from both sources are consumed without a write enable.
    setAlu(1, 0, 32'h55);
    setLsu(1, 0, 32'h66);
    applyStimulus();
    idle(3);

    // Reset with two buffered entries held back by ALU traffic.
    setAlu(1, 4, 32'h44);
    setLsu(1, 5, 32'h5);
    applyStimulus();
    setLsu(1, 6, 32'h6);
    applyStimulus();
    applyReset();
    idle(4);

    // Randomised traffic obeying the hold-while-not-accepted protocol.
    setAlu(0, 0, 0);
    setLsu(0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (!(aluV && lastStall)) setAlu(($urandom_range(0, 99) < 60), AW'($urandom), $urandom);
      if (!(lsuV && !lastReady)) setLsu(($urandom_range(0, 99) < 45), AW'($urandom), $urandom);
      if (c == 1500) applyReset();
      applyStimulus();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
